// File: rtl/swim_cmd_sched_pkg.sv
// Shared encodings for the SWIM command scheduler: FSM states, command bytes and
// response bytes, plus the status-byte packing used by the '?' command.
`timescale 1ns/1ps
package swim_cmd_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RST_LOW   = 3'd1,
      ST_SEQ_START = 3'd2,
      ST_SEQ_WAIT  = 3'd3,
      ST_RESPOND   = 3'd4
   } state_t;

   typedef enum logic {
      MODE_R = 1'b0,
      MODE_E = 1'b1
   } mode_t;

   localparam logic [7:0] CMD_RST       = 8'h52;
   localparam logic [7:0] CMD_ENTRY     = 8'h45;
   localparam logic [7:0] CMD_STAT      = 8'h3F;

   localparam logic [7:0] RSP_RST       = 8'h72;
   localparam logic [7:0] RSP_ENTRY     = 8'h65;
   localparam logic [7:0] RSP_TMO       = 8'h54;
   localparam logic [7:0] RSP_NAK       = 8'h21;
   localparam logic [7:0] RSP_STAT_BASE = 8'h30;

   // Status byte: ASCII '0'..'?' range, low nibble = {swim, timeout, nrst, 0}.
   function automatic logic [7:0] stat_byte(input logic swim, input logic tmo, input logic nrst);
      return RSP_STAT_BASE | {4'b0000, swim, tmo, nrst, 1'b0};
   endfunction

endpackage

// File: rtl/swim_cmd_sched_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs (SWIM pin level, or
// seq_busy when the pattern generator runs in another clock domain).
`timescale 1ns/1ps
module swim_cmd_sched_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/swim_cmd_sched.sv
// Command scheduler: turns one host command byte into an NRST hold and/or SWIM
// entry sequence and returns exactly one response byte per accepted command.
`timescale 1ns/1ps
module swim_cmd_sched
   import swim_cmd_sched_pkg::*;
#(
   parameter int RST_CYCLES     = 48000,
   parameter int TIMEOUT_CYCLES = 480000,
   parameter int CNT_W          = 20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       nrst_oe,
   output logic       seq_start,
   input  logic       seq_busy,
   input  logic       swim_in,
   output state_t     state_dbg
);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   mode_t            mode;
   logic [CNT_W-1:0] counter;
   logic             timeout_flag;
   logic             seen_busy;
   logic             sync_swim;

   swim_cmd_sched_sync u_swim_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (swim_in),
      .q       (sync_swim)
   );

   assign state_dbg = state;

   // Handshakes: a byte moves on a rising clk edge where valid and ready are both 1.
   // cmd_ready is high only in IDLE; rsp_valid holds with rsp_data stable until rsp_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         mode         <= MODE_R;
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= 8'h00;
         nrst_oe      <= 1'b0;
         seq_start    <= 1'b0;
         counter      <= '0;
         timeout_flag <= 1'b0;
         seen_busy    <= 1'b0;
      end else begin
         seq_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  counter   <= '0;
                  case (cmd_data)
                     CMD_RST: begin
                        state   <= ST_RST_LOW;
                        mode    <= MODE_R;
                        nrst_oe <= 1'b1;
                     end
                     CMD_ENTRY: begin
                        state   <= ST_RST_LOW;
                        mode    <= MODE_E;
                        nrst_oe <= 1'b1;
                     end
                     CMD_STAT: begin
                        state    <= ST_RESPOND;
                        rsp_data <= stat_byte(sync_swim, timeout_flag, nrst_oe);
                     end
                     default: begin
                        state    <= ST_RESPOND;
                        rsp_data <= RSP_NAK;
                     end
                  endcase
               end else begin
                  cmd_ready <= 1'b1;
               end
            end

            ST_RST_LOW: begin
               if (counter == RST_LAST) begin
                  counter <= '0;
                  if (mode == MODE_R) begin
                     state    <= ST_RESPOND;
                     rsp_data <= RSP_RST;
                     nrst_oe  <= 1'b0;
                  end else begin
                     state     <= ST_SEQ_START;
                     seq_start <= 1'b1;
                  end
               end else if (counter != CNT_MAX) begin
                  counter <= counter + 1'b1;
               end
            end

            ST_SEQ_START: begin
               state     <= ST_SEQ_WAIT;
               counter   <= '0;
               seen_busy <= 1'b0;
            end

            ST_SEQ_WAIT: begin
               if (seq_busy) begin
                  seen_busy <= 1'b1;
               end
               // Completion is checked before the timeout so a late finish still succeeds.
               if (seen_busy && !seq_busy) begin
                  state        <= ST_RESPOND;
                  rsp_data     <= RSP_ENTRY;
                  timeout_flag <= 1'b0;
                  nrst_oe      <= 1'b0;
                  counter      <= '0;
               end else if (counter == TMO_LAST) begin
                  state        <= ST_RESPOND;
                  rsp_data     <= RSP_TMO;
                  timeout_flag <= 1'b1;
                  nrst_oe      <= 1'b0;
                  counter      <= '0;
               end else if (counter != CNT_MAX) begin
                  counter <= counter + 1'b1;
               end
            end

            ST_RESPOND: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  counter   <= '0;
                  state     <= ST_IDLE;
               end else begin
                  rsp_valid <= 1'b1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_swim_cmd_sched.sv
// Directed bench for swim_cmd_sched with short NRST/timeout windows; responses are
// collected by a monitor and compared in order against hand-computed expected bytes.
`timescale 1ns/1ps
module tb_swim_cmd_sched;
   import swim_cmd_sched_pkg::*;

   localparam int RST_C = 16;
   localparam int TMO_C = 64;

   logic       clk;
   logic       reset_n;
   logic [7:0] cmd_data;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] rsp_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       nrst_oe;
   logic       seq_start;
   logic       seq_busy;
   logic       swim_in;
   state_t     state_dbg;

   swim_cmd_sched #(
      .RST_CYCLES     (RST_C),
      .TIMEOUT_CYCLES (TMO_C),
      .CNT_W          (20)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_data  (cmd_data),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .rsp_data  (rsp_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .nrst_oe   (nrst_oe),
      .seq_start (seq_start),
      .seq_busy  (seq_busy),
      .swim_in   (swim_in),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   // ---------------- monitor / scoreboard ----------------
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  nrst_cnt = 0;
   int  start_cnt = 0;
   int  valid_cnt = 0;
   int  rise_cyc = 0;
   int  acc_cyc = 0;
   logic rsp_valid_q = 1'b0;
   real drop_time = -1.0;

   always @(posedge clk) cyc++;

   always @(negedge nrst_oe) drop_time = $realtime;

   always @(negedge clk) begin
      if (reset_n) begin
         if (nrst_oe)   nrst_cnt++;
         if (seq_start) start_cnt++;
         if (rsp_valid) valid_cnt++;
         if (rsp_valid && !rsp_valid_q) rise_cyc = cyc;
         if (rsp_valid && rsp_ready) got_q.push_back(rsp_data);
      end
      rsp_valid_q = rsp_valid;
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves cmd_valid high so back-to-back sends need no idle cycle.
   task automatic send_cmd(input logic [7:0] b);
      int   k;
      logic acc;
      k   = 0;
      acc = 1'b0;
      cmd_data  = b;
      cmd_valid = 1'b1;
      while (!acc && k < 200) begin
         @(negedge clk);
         acc = cmd_ready;
         @(posedge clk);
         #1;
         k++;
      end
      check("cmd_accept", 32'(acc), 1);
      acc_cyc = cyc;
   endtask

   task automatic expect_rsp(input string tag, input int budget);
      int k;
      k = 0;
      while (got_q.size() == 0 && k < budget) begin
         step(1);
         k++;
      end
      check({tag, "_arrived"}, 32'(got_q.size() > 0), 1);
      if (got_q.size() > 0 && exp_q.size() > 0)
         check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
   endtask

   // ---------------- directed sequence ----------------
   int nb, sb, vb, k, bad, acc1, acc2;
   real t_rst;

   initial begin
      reset_n   = 1'b1;
      cmd_data  = 8'h00;
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      seq_busy  = 1'b0;
      swim_in   = 1'b0;
      #3 reset_n = 1'b0;
      step(3);

      // reset state
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data",  32'(rsp_data),  0);
      check("rst_nrst_oe",   32'(nrst_oe),   0);
      check("rst_seq_start", 32'(seq_start), 0);
      check("rst_state",     32'(state_dbg), 32'(ST_IDLE));
      reset_n = 1'b1;
      @(negedge clk);
      check("release_cmd_ready_low", 32'(cmd_ready), 0);
      step(1);
      check("release_cmd_ready_high", 32'(cmd_ready), 1);

      // 1: 'R' -> 16 NRST cycles, 'r', one valid beat, latency 17
      rsp_ready = 1'b1;
      nb = nrst_cnt; vb = valid_cnt; sb = start_cnt;
      exp_q.push_back(8'h72);
      send_cmd(8'h52);
      cmd_valid = 1'b0;
      expect_rsp("r_rsp", 60);
      step(2);
      check("r_nrst_cycles", nrst_cnt - nb, RST_C);
      check("r_latency", rise_cyc - acc_cyc, RST_C + 1);
      check("r_valid_beats", valid_cnt - vb, 1);
      check("r_no_seq_start", start_cnt - sb, 0);

      // 2: 'E' with busy pulse 5 cycles after seq_start, 10 cycles long
      nb = nrst_cnt; sb = start_cnt;
      exp_q.push_back(8'h65);
      send_cmd(8'h45);
      cmd_valid = 1'b0;
      k = 0;
      while (!seq_start && k < 100) begin
         step(1);
         k++;
      end
      check("e_seq_start_seen", 32'(seq_start), 1);
      check("e_nrst_before_start", nrst_cnt - nb, RST_C);
      step(5);
      seq_busy = 1'b1;
      step(10);
      seq_busy = 1'b0;
      check("e_nrst_held_busy_fall", 32'(nrst_oe), 1);
      step(1);
      check("e_nrst_released", 32'(nrst_oe), 0);
      expect_rsp("e_rsp", 20);
      check("e_nrst_cycles", nrst_cnt - nb, 2 * RST_C);
      check("e_one_start_pulse", start_cnt - sb, 1);

      // status after a successful entry: no timeout, swim low
      exp_q.push_back(8'h30);
      send_cmd(8'h3F);
      cmd_valid = 1'b0;
      expect_rsp("stat_ok_rsp", 20);

      // 3: 'E' with seq_busy never rising -> 'T' after 64 wait cycles
      swim_in = 1'b1;
      nb = nrst_cnt; sb = start_cnt;
      exp_q.push_back(8'h54);
      send_cmd(8'h45);
      cmd_valid = 1'b0;
      expect_rsp("tmo_rsp", 200);
      check("tmo_nrst_cycles", nrst_cnt - nb, RST_C + 1 + TMO_C);
      check("tmo_one_start_pulse", start_cnt - sb, 1);
      // swim=1, timeout=1, nrst=0 -> 0x30|0x08|0x04
      exp_q.push_back(8'h3C);
      send_cmd(8'h3F);
      cmd_valid = 1'b0;
      expect_rsp("stat_tmo_rsp", 20);

      // 4: unknown byte with host stalling the response
      swim_in   = 1'b0;
      rsp_ready = 1'b0;
      nb = nrst_cnt; sb = start_cnt;
      exp_q.push_back(8'h21);
      send_cmd(8'h7A);
      cmd_valid = 1'b0;
      step(1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (!(rsp_valid === 1'b1 && rsp_data === 8'h21 && cmd_ready === 1'b0)) bad++;
         step(1);
      end
      check("nak_hold_stable", bad, 0);
      rsp_ready = 1'b1;
      expect_rsp("nak_rsp", 20);
      check("nak_no_nrst", nrst_cnt - nb, 0);
      check("nak_no_seq_start", start_cnt - sb, 0);

      // 5: asynchronous reset in the middle of RST_LOW
      exp_q.push_back(8'h72);
      send_cmd(8'h52);
      cmd_valid = 1'b0;
      step(5);
      check("arst_nrst_before", 32'(nrst_oe), 1);
      #2;
      reset_n = 1'b0;
      t_rst = $realtime;
      #1;
      check("arst_nrst_oe", 32'(nrst_oe), 0);
      check("arst_same_timestep", 32'(drop_time == t_rst), 1);
      check("arst_rsp_valid", 32'(rsp_valid), 0);
      check("arst_state", 32'(state_dbg), 32'(ST_IDLE));
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1);
      check("arst_no_response", got_q.size(), 0);
      nb = nrst_cnt;
      exp_q.push_back(8'h72);
      send_cmd(8'h52);
      cmd_valid = 1'b0;
      expect_rsp("arst_r_rsp", 60);
      step(2);
      check("arst_r_nrst_cycles", nrst_cnt - nb, RST_C);

      // 6: back-to-back '?','?','R' with cmd_valid held; reset cleared timeout_flag
      swim_in = 1'b1;
      step(3);
      exp_q.push_back(8'h38);
      exp_q.push_back(8'h38);
      exp_q.push_back(8'h72);
      send_cmd(8'h3F);
      acc1 = acc_cyc;
      send_cmd(8'h3F);
      acc2 = acc_cyc;
      send_cmd(8'h52);
      cmd_valid = 1'b0;
      check("b2b_turnaround", acc2 - acc1, 3);
      expect_rsp("b2b_rsp0", 20);
      expect_rsp("b2b_rsp1", 20);
      expect_rsp("b2b_rsp2", 60);
      step(3);
      check("b2b_no_extra_rsp", got_q.size(), 0);
      check("end_state", 32'(state_dbg), 32'(ST_IDLE));
      check("end_nrst_oe", 32'(nrst_oe), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
